// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Consumes the slow output of the clock divider as a data signal on the fast
// system clock. Each rising edge of that signal, when enabled, is a "step"
// that advances one of four LED patterns by one position:
//   OFF    : all LEDs dark
//   BOUNCE : a block of TRAIL_LEN lit LEDs sweeps left and right
//   FILL   : LEDs fill up from bit 0, then drain back down to empty
//   BLINK  : all LEDs toggle together
// A mode change is only honoured at a step, and that step loads the new
// pattern's starting value instead of advancing the old pattern.
// led and phase come straight from flops; no input reaches them combinationally.

module led_pattern_ctrl #(
    parameter int LED_NUM   = 16,
    parameter int TRAIL_LEN = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               clk_div,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               phase
);

    // Mode encodings as seen on the mode input
    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    // Starting / reload values for the LED register
    localparam logic [LED_NUM-1:0] LED_ZERO     = '0;
    localparam logic [LED_NUM-1:0] LED_ALL      = '1;
    localparam logic [LED_NUM-1:0] LED_ONE      = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_BOUNCE_0 =
        {{(LED_NUM-TRAIL_LEN){1'b0}}, {TRAIL_LEN{1'b1}}};

    // Pattern states. phase is 1 in the "outgoing" half of each pattern:
    // MOVE_L, FILL_UP and BLINK_ON.
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        MOVE_L    = 3'd1,
        MOVE_R    = 3'd2,
        FILL_UP   = 3'd3,
        DRAIN     = 3'd4,
        BLINK_ON  = 3'd5,
        BLINK_OFF = 3'd6
    } state_t;

    state_t     state_reg;
    logic       clk_div_q;
    logic [1:0] mode_q;
    logic       step;
    logic       led_msb;
    logic       led_lsb;
    logic       led_full;
    logic       led_empty;

    // Rising edge of the divided clock, gated by the enable. clk_div_q keeps
    // tracking clk_div while en=0, so raising en during a high phase of
    // clk_div cannot produce a spurious step.
    always_comb begin
        step      = clk_div & ~clk_div_q & en;
        led_msb   = led[LED_NUM-1];
        led_lsb   = led[0];
        led_full  = (led == LED_ALL);
        led_empty = (led == LED_ZERO);
    end

    // Edge-detect register, mode latch and pattern FSM with registered led/phase
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            clk_div_q <= 1'b0;
            mode_q    <= MODE_OFF;
            led       <= LED_ZERO;
            phase     <= 1'b0;
            state_reg <= S_OFF;
        end else begin
            clk_div_q <= clk_div;
            if (step) begin
                if (mode != mode_q) begin
                    // New mode: load its starting value, no advance this step
                    mode_q <= mode;
                    case (mode)
                        MODE_BOUNCE: begin
                            led       <= LED_BOUNCE_0;
                            state_reg <= MOVE_L;
                            phase     <= 1'b1;
                        end
                        MODE_FILL: begin
                            led       <= LED_ONE;
                            state_reg <= FILL_UP;
                            phase     <= 1'b1;
                        end
                        MODE_BLINK: begin
                            led       <= LED_ALL;
                            state_reg <= BLINK_ON;
                            phase     <= 1'b1;
                        end
                        default: begin
                            led       <= LED_ZERO;
                            state_reg <= S_OFF;
                            phase     <= 1'b0;
                        end
                    endcase
                end else begin
                    // Same mode: advance the running pattern by one position
                    case (state_reg)
                        MOVE_L: begin
                            if (led_msb) begin
                                led       <= led >> 1;
                                state_reg <= MOVE_R;
                                phase     <= 1'b0;
                            end else begin
                                led       <= led << 1;
                                phase     <= 1'b1;
                            end
                        end
                        MOVE_R: begin
                            if (led_lsb) begin
                                led       <= led << 1;
                                state_reg <= MOVE_L;
                                phase     <= 1'b1;
                            end else begin
                                led       <= led >> 1;
                                phase     <= 1'b0;
                            end
                        end
                        FILL_UP: begin
                            if (led_full) begin
                                led       <= led >> 1;
                                state_reg <= DRAIN;
                                phase     <= 1'b0;
                            end else begin
                                led       <= (led << 1) | LED_ONE;
                                phase     <= 1'b1;
                            end
                        end
                        DRAIN: begin
                            if (led_empty) begin
                                led       <= LED_ONE;
                                state_reg <= FILL_UP;
                                phase     <= 1'b1;
                            end else begin
                                led       <= led >> 1;
                                phase     <= 1'b0;
                            end
                        end
                        BLINK_ON: begin
                            led       <= LED_ZERO;
                            state_reg <= BLINK_OFF;
                            phase     <= 1'b0;
                        end
                        BLINK_OFF: begin
                            led       <= LED_ALL;
                            state_reg <= BLINK_ON;
                            phase     <= 1'b1;
                        end
                        default: begin
                            // S_OFF (and any unused encoding) parks dark
                            led       <= LED_ZERO;
                            state_reg <= S_OFF;
                            phase     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl: directed sequences from the pattern rules,
// then randomized clk_div/en/mode/reset activity, all checked every clk_in
// cycle against a reference model that computes the expected LED word from
// "steps since the mode was loaded" using plain arithmetic.

module tb_led_pattern_ctrl;

    localparam int LN = 16;
    localparam int TL = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          clk_div;
    logic          en;
    logic [1:0]    mode;
    logic [LN-1:0] led;
    logic          phase;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic          m_prev;
    logic [1:0]    m_mq;
    int            m_k;
    logic [LN-1:0] exp_led;
    logic          exp_phase;
    logic          m_step;

    led_pattern_ctrl #(
        .LED_NUM   (LN),
        .TRAIL_LEN (TL)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .en      (en),
        .mode    (mode),
        .led     (led),
        .phase   (phase)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Word with the low n bits set
    function automatic logic [LN-1:0] ones(input int n);
        logic [LN-1:0] v;
        v = '0;
        for (int i = 0; i < LN; i++)
            if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    // Expected LED word k steps after mode m was loaded
    function automatic logic [LN-1:0] model_led(input logic [1:0] m, input int k);
        int d;
        int mm;
        int n;
        int j;
        d = LN - TL;
        case (m)
            2'b01: begin
                if (k == 0) n = 0;
                else begin
                    mm = ((k - 1) % (2 * d)) + 1;
                    n  = (mm <= d) ? mm : 2 * d - mm;
                end
                return ones(TL) << n;
            end
            2'b10: begin
                j = k % (2 * LN);
                n = (j < LN) ? j + 1 : 2 * LN - 1 - j;
                return ones(n);
            end
            2'b11:   return (k % 2 == 0) ? ones(LN) : '0;
            default: return '0;
        endcase
    endfunction

    function automatic logic model_phase(input logic [1:0] m, input int k);
        int d;
        d = LN - TL;
        case (m)
            2'b01:   return (k == 0) ? 1'b1 : ((((k - 1) % (2 * d)) + 1) <= d);
            2'b10:   return (k % (2 * LN)) < LN;
            2'b11:   return (k % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    // One clk_in cycle: update the model from the inputs the DUT sampled,
    // then compare outputs shortly after the edge.
    task automatic cycle();
        @(posedge clk_in);
        m_step = 1'b0;
        if (!rst_n) begin
            m_prev = 1'b0;
            m_mq   = 2'b00;
            m_k    = 0;
        end else begin
            m_step = clk_div && !m_prev && en;
            m_prev = clk_div;
            if (m_step) begin
                if (mode != m_mq) begin
                    m_mq = mode;
                    m_k  = 0;
                end else begin
                    m_k++;
                end
            end
        end
        exp_led   = model_led(m_mq, m_k);
        exp_phase = model_phase(m_mq, m_k);
        #1;
        check_val("led", 32'(led), 32'(exp_led));
        check_val("phase", 32'(phase), 32'(exp_phase));
        if (m_step)
            $display("step mode=%b k=%0d led=%h phase=%b", m_mq, m_k, led, phase);
    endtask

    // One divided-clock period: low for 4 cycles, then high for 4
    task automatic div_period();
        clk_div = 1'b0;
        repeat (4) cycle();
        clk_div = 1'b1;
        repeat (4) cycle();
    endtask

    initial begin
        int run;
        rst_n   = 1'b0;
        clk_div = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        m_prev  = 1'b0;
        m_mq    = 2'b00;
        m_k     = 0;

        // Reset hold with clk_div toggling
        for (int i = 0; i < 3; i++) begin
            clk_div = ~clk_div;
            cycle();
        end
        check_val("rst_led", 32'(led), 32'h0000);
        check_val("rst_phase", 32'(phase), 32'h0);

        // OFF mode stays dark
        rst_n   = 1'b1;
        en      = 1'b1;
        clk_div = 1'b0;
        repeat (5) div_period();
        check_val("off_led", 32'(led), 32'h0000);

        // BLINK
        mode = 2'b11;
        div_period();
        check_val("blink_on", 32'(led), 32'hFFFF);
        div_period();
        check_val("blink_off", 32'(led), 32'h0000);

        // en=0 freezes
        en = 1'b0;
        repeat (2) div_period();
        check_val("en0_frozen", 32'(led), 32'h0000);

        // Raise en while clk_div already high: no step until next rising edge
        clk_div = 1'b0;
        repeat (2) cycle();
        clk_div = 1'b1;
        repeat (2) cycle();
        en = 1'b1;
        repeat (3) cycle();
        check_val("en_mid_high", 32'(led), 32'h0000);
        div_period();
        check_val("en_next_edge", 32'(led), 32'hFFFF);

        // BOUNCE
        mode = 2'b01;
        div_period();
        check_val("bounce_init", 32'(led), 32'h000F);
        repeat (12) div_period();
        check_val("bounce_s12", 32'(led), 32'hF000);
        div_period();
        check_val("bounce_s13", 32'(led), 32'h7800);
        check_val("bounce_s13_ph", 32'(phase), 32'h0);
        repeat (11) div_period();
        check_val("bounce_s24", 32'(led), 32'h000F);

        // FILL, then mode change mid-pattern
        mode = 2'b10;
        div_period();
        check_val("fill_init", 32'(led), 32'h0001);
        repeat (7) div_period();
        check_val("fill_s7", 32'(led), 32'h00FF);
        mode = 2'b01;
        div_period();
        check_val("chg_led", 32'(led), 32'h000F);
        check_val("chg_phase", 32'(phase), 32'h1);

        // Reset mid-BOUNCE
        repeat (8) div_period();
        check_val("bounce_s8", 32'(led), 32'h0F00);
        clk_div = 1'b0;
        rst_n   = 1'b0;
        cycle();
        check_val("midrst_led", 32'(led), 32'h0000);
        rst_n = 1'b1;
        div_period();
        check_val("midrst_reload", 32'(led), 32'h000F);

        // Full FILL cycle
        mode = 2'b10;
        div_period();
        repeat (15) div_period();
        check_val("fill_s15", 32'(led), 32'hFFFF);
        repeat (16) div_period();
        check_val("fill_s31", 32'(led), 32'h0000);
        div_period();
        check_val("fill_s32", 32'(led), 32'h0001);

        // Randomized activity, every cycle checked against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
            en      = ($urandom_range(0, 7) != 0);
            rst_n   = ($urandom_range(0, 49) != 0);
            clk_div = ~clk_div;
            run     = $urandom_range(1, 6);
            for (int c = 0; c < run; c++) begin
                cycle();
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
